// File: rtl/peripheral_mpram_1r1w_arbiter.sv
// Two-requester arbiter in front of a 1R1W RAM: writes and reads are arbitrated
// separately with round-robin pointers, and a read colliding with a granted write is held off.
module peripheral_mpram_1r1w_arbiter #(
    parameter  int ABITS = 10,
    parameter  int DBITS = 32,
    localparam int BE    = (DBITS + 7) / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  logic [1:0]           req_we_i,
    input  logic [2*ABITS-1:0]   req_addr_i,
    input  logic [2*DBITS-1:0]   req_wdata_i,
    input  logic [2*BE-1:0]      req_be_i,
    output logic [1:0]           rsp_valid_o,
    output logic [DBITS-1:0]     rsp_rdata_o,
    output logic [ABITS-1:0]     mem_waddr_o,
    output logic [DBITS-1:0]     mem_din_o,
    output logic                 mem_we_o,
    output logic [BE-1:0]        mem_be_o,
    output logic [ABITS-1:0]     mem_raddr_o,
    input  logic [DBITS-1:0]     mem_dout_i,
    output logic [15:0]          conflict_cnt_o
);

    logic [1:0][ABITS-1:0] addr;
    logic [1:0][DBITS-1:0] wdata;
    logic [1:0][BE-1:0]    be;

    for (genvar k = 0; k < 2; k++) begin : g_req
        assign addr[k]  = req_addr_i[k*ABITS +: ABITS];
        assign wdata[k] = req_wdata_i[k*DBITS +: DBITS];
        assign be[k]    = req_be_i[k*BE +: BE];
    end

    logic       wptr, rptr;
    logic [1:0] wr_req, rd_req;
    logic [1:0] wgnt, rgnt_raw, rgnt;
    logic       w_idx, r_idx;
    logic       denied;
    logic [1:0] rsp_valid_q;
    logic [15:0] cnt_q;

    // Nothing is granted while reset is held, so the RAM never sees a write then.
    assign wr_req = req_valid_i &  req_we_i & {2{rst_ni}};
    assign rd_req = req_valid_i & ~req_we_i & {2{rst_ni}};

    always_comb begin
        wgnt     = '0;
        rgnt_raw = '0;
        if (wr_req == 2'b11) wgnt[wptr] = 1'b1;
        else                 wgnt = wr_req;
        if (rd_req == 2'b11) rgnt_raw[rptr] = 1'b1;
        else                 rgnt_raw = rd_req;
        w_idx = wgnt[1];
        r_idx = rgnt_raw[1];
        // Same-address read/write in one cycle: the write wins, the read retries.
        rgnt = rgnt_raw;
        if ((|wgnt) && (|rgnt_raw) && (addr[w_idx] == addr[r_idx])) rgnt = '0;
    end

    assign req_ready_o = wgnt | rgnt;
    assign denied      = |(req_valid_i & ~req_ready_o);

    assign mem_we_o    = |wgnt;
    assign mem_waddr_o = mem_we_o ? addr[w_idx]  : '0;
    assign mem_din_o   = mem_we_o ? wdata[w_idx] : '0;
    assign mem_be_o    = mem_we_o ? be[w_idx]    : '0;
    assign mem_raddr_o = (|rgnt) ? addr[rgnt[1]] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= '0;
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= rgnt;
            if (|wgnt) wptr <= ~w_idx;
            if (|rgnt) rptr <= ~rgnt[1];
            if (denied && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = mem_dout_i;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: doc/peripheral_mpram_1r1w_arbiter.md
PERIPHERAL_MPRAM_1R1W_ARBITER -- requirements
Module: peripheral_mpram_1r1w_arbiter

Interface
REQ-001 SHALL have parameter ABITS, default 10, memory address width.
REQ-002 SHALL have parameter DBITS, default 32, data width; BE = (DBITS+7)/8.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  2  request valid, bit k = requester k.
REQ-006 SHALL have port req_ready_o  output  2  request accepted this cycle (combinational).
REQ-007 SHALL have port req_we_i  input  2  1 = write, 0 = read.
REQ-008 SHALL have port req_addr_i  input  2*ABITS  address; requester k at [k*ABITS+:ABITS].
REQ-009 SHALL have port req_wdata_i  input  2*DBITS  write data, packed as addr.
REQ-010 SHALL have port req_be_i  input  2*BE  byte enables, packed as addr.
REQ-011 SHALL have port rsp_valid_o  output  2  read data valid for requester k.
REQ-012 SHALL have port rsp_rdata_o  output  DBITS  read data, shared by both requesters.
REQ-013 SHALL have ports mem_waddr_o ABITS, mem_din_o DBITS, mem_we_o 1, mem_be_o BE, all outputs, driving the RAM write side.
REQ-014 SHALL have ports mem_raddr_o  output  ABITS and mem_dout_i  input  DBITS, the RAM read side (1-cycle registered read, no write-to-read bypass).
REQ-015 SHALL have port conflict_cnt_o  output  16  saturating count of cycles with at least one denied valid request.

Function
REQ-016 SHALL complete a transfer for requester k when req_valid_i[k] and req_ready_o[k] are both 1 at a rising edge; each requester issues one operation per cycle.
REQ-017 SHALL arbitrate writes independently of reads: write and read ports serve different requesters in the same cycle.
REQ-018 SHALL, when both requesters present writes, grant the one selected by write pointer wptr and deny the other; when one presents a write, grant it.
REQ-019 SHALL set wptr to the non-granted requester index at every edge where a write is granted; wptr SHALL hold otherwise.
REQ-020 SHALL apply REQ-018/019 identically to reads using read pointer rptr.
REQ-021 SHALL deny the granted read (ready 0, rptr held) when a write is granted in the same cycle to an equal address; the write proceeds; this counts as a conflict.
REQ-022 SHALL drive mem_we_o = 1 and mem_waddr_o/mem_din_o/mem_be_o from the write winner in the grant cycle; when no write is granted, mem_we_o, mem_waddr_o, mem_din_o and mem_be_o SHALL be 0.
REQ-023 SHALL drive mem_raddr_o from the read winner; 0 when no read is granted.
REQ-024 SHALL write with req_be all-zero as a granted write with mem_be_o = 0 (no data change).
REQ-025 SHALL assert rsp_valid_o[k] for exactly one cycle, the cycle after requester k's read is accepted; at most one bit set.
REQ-026 SHALL drive rsp_rdata_o = mem_dout_i combinationally; valid only when rsp_valid_o != 0.
REQ-027 SHALL have read latency exactly 1 cycle from accept to rsp_valid; back-to-back reads at full rate; no response backpressure.
REQ-028 SHALL return, for a read accepted one or more cycles after a write to the same address, the written data.
REQ-029 SHALL increment conflict_cnt_o by 1 per cycle with any denied valid request, saturating at 16'hFFFF.

Reset
REQ-030 SHALL, on rst_ni low, asynchronously clear rsp_valid_o to 0, wptr and rptr to 0 (requester 0 priority), conflict_cnt_o to 0.
REQ-031 SHALL drop any response outstanding at reset assertion; no rsp_valid_o after release for pre-reset reads.
REQ-032 SHALL keep req_ready_o and mem_* outputs combinational; mem_we_o SHALL be 0 while rst_ni is low.

Verification
REQ-033 Reset, then requester 0 writes 0xDEADBEEF to addr 5 (be=4'hF), next cycle reads addr 5 -> rsp_valid_o=2'b01 one cycle after accept, rsp_rdata_o=0xDEADBEEF.
REQ-034 Both write same cycle after reset, held valid -> cycle 1 grants 0, cycle 2 grants 1; conflict_cnt_o=1.
REQ-035 Requester 0 writes addr 9 while requester 1 reads addr 9 same cycle -> read denied, accepted next cycle, returns new data.
REQ-036 Requester 0 writes addr 3 while requester 1 reads addr 4 -> both ready=1, same cycle, no conflict count.
REQ-037 Byte write 0x000000AB be=4'b0001 over 0x11223344 -> read returns 0x112233AB.
REQ-038 Assert rst_ni low the cycle after a read accept -> rsp_valid_o stays 2'b00, pointers and counter 0.
